// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: FSM states, note codes,
// RAM entry layout and the note-code to one-hot select mapping.
package melody_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_NOTE  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    localparam logic [2:0] NOTE_REST = 3'd0;
    localparam logic [2:0] NOTE_DOI  = 3'd1;
    localparam logic [2:0] NOTE_RE   = 3'd2;
    localparam logic [2:0] NOTE_MI   = 3'd3;
    localparam logic [2:0] NOTE_FA   = 3'd4;
    localparam logic [2:0] NOTE_SO   = 3'd5;

    // Entry layout: {note[2:0], duration[3:0]}
    localparam int ENTRY_W  = 7;
    localparam int NOTE_LSB = 4;
    localparam int NOTE_W   = 3;
    localparam int DUR_LSB  = 0;
    localparam int DUR_W    = 4;

    // Codes 0, 6 and 7 are rests and map to a silent select.
    function automatic logic [4:0] note_to_select(input logic [NOTE_W-1:0] code);
        logic [4:0] sel;
        sel = 5'b00000;
        case (code)
            NOTE_DOI: sel = 5'b00001;
            NOTE_RE:  sel = 5'b00010;
            NOTE_MI:  sel = 5'b00100;
            NOTE_FA:  sel = 5'b01000;
            NOTE_SO:  sel = 5'b10000;
            default:  sel = 5'b00000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/melody_ram.sv
// Melody entry store: one write port, one registered read port, no reset.
// A same-cycle write to the address being read is forwarded to the read data.
module melody_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 7
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/melody_sequencer.sv
// Steps through stored note/duration entries and drives a one-hot note select.
// Optional MELODY_LOOP_EN: wrap to entry 0 at the end instead of finishing.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int UNIT_CYCLES = 1000000,
    parameter int GAP_CYCLES  = 50000,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               start,
    input  logic               stop,
    output logic [4:0]         select,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      index
);

    localparam int CW = $clog2(15 * UNIT_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [AW-1:0]      index_q, index_d;
    logic [CW-1:0]      dur_cnt_q, dur_cnt_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [4:0]         select_q, select_d;
    logic               done_q, done_d;

    logic               ram_we;
    logic [ENTRY_W-1:0] rd_data;
    logic [NOTE_W-1:0]  rd_note;
    logic [DUR_W-1:0]   rd_dur;
    logic               advance;
    logic               finish;

    assign ram_we  = wr_en && (state_q == ST_IDLE);
    assign rd_note = rd_data[NOTE_LSB +: NOTE_W];
    assign rd_dur  = rd_data[DUR_LSB +: DUR_W];

    // Reading at index_d means the entry is already on rd_data during FETCH.
    melody_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (index_d),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        dur_cnt_d = dur_cnt_q;
        gap_cnt_d = gap_cnt_q;
        select_d  = select_q;
        done_d    = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                select_d = '0;
                if (start && !stop) begin
                    state_d = ST_FETCH;
                    index_d = '0;
                end
            end
            ST_FETCH: begin
                select_d = '0;
                if (rd_dur == '0) begin
`ifdef MELODY_LOOP_EN
                    // An end marker at entry 0 still finishes so an empty melody cannot spin.
                    if (index_q != '0) begin
                        state_d = ST_FETCH;
                        index_d = '0;
                    end else begin
                        finish = 1'b1;
                    end
`else
                    finish = 1'b1;
`endif
                end else begin
                    state_d   = ST_NOTE;
                    select_d  = note_to_select(rd_note);
                    dur_cnt_d = CW'(rd_dur) * CW'(UNIT_CYCLES);
                end
            end
            ST_NOTE: begin
                if (dur_cnt_q <= CW'(1)) begin
                    dur_cnt_d = '0;
                    select_d  = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GW'(GAP_CYCLES);
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    dur_cnt_d = dur_cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                select_d = '0;
                if (gap_cnt_q <= GW'(1)) begin
                    gap_cnt_d = '0;
                    advance   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (index_q == LAST_IDX) begin
`ifdef MELODY_LOOP_EN
                state_d = ST_FETCH;
                index_d = '0;
`else
                finish = 1'b1;
`endif
            end else begin
                state_d = ST_FETCH;
                index_d = index_q + 1'b1;
            end
        end

        if (finish) begin
            state_d = ST_IDLE;
            index_d = '0;
            done_d  = 1'b1;
        end

        // Abort overrides everything, including a completion in the same cycle.
        if (stop && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            index_d   = '0;
            select_d  = '0;
            dur_cnt_d = '0;
            gap_cnt_d = '0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            dur_cnt_q <= '0;
            gap_cnt_q <= '0;
            select_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            dur_cnt_q <= dur_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            select_q  <= select_d;
            done_q    <= done_d;
        end
    end

    assign select = select_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign index  = index_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with DEPTH=4, UNIT_CYCLES=4, GAP_CYCLES=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_melody_sequencer;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [6:0] wr_data;
    logic       start;
    logic       stop;
    logic [4:0] select;
    logic       busy;
    logic       done;
    logic [1:0] index;

    int n_cmp = 0;
    int n_err = 0;

    melody_sequencer #(
        .DEPTH       (4),
        .UNIT_CYCLES (4),
        .GAP_CYCLES  (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .stop    (stop),
        .select  (select),
        .busy    (busy),
        .done    (done),
        .index   (index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input int addr, input int note, input int dur);
        logic [2:0] n;
        logic [3:0] d;
        n       = 3'(note);
        d       = 4'(dur);
        wr_en   = 1'b1;
        wr_addr = 2'(addr);
        wr_data = {n, d};
        @(negedge clk);
        wr_en   = 1'b0;
        $display("write addr=%0d note=%0d dur=%0d", addr, note, dur);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        stop    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_select", select, 5'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_index", index, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic playback: doi x2, mi x1, end marker
        write_entry(0, 1, 2);
        write_entry(1, 3, 1);
        write_entry(2, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("basic_fetch_busy", busy, 1'b1);
        check("basic_fetch_select", select, 5'd0);
        repeat (8) begin
            @(negedge clk);
            check("basic_doi", select, 5'b00001);
        end
        repeat (3) begin
            @(negedge clk);
            check("basic_gap1", select, 5'd0);
        end
        repeat (4) begin
            @(negedge clk);
            check("basic_mi", select, 5'b00100);
            check("basic_mi_index", index, 2'd1);
        end
        repeat (2) begin
            @(negedge clk);
            check("basic_gap2", select, 5'd0);
            check("basic_gap2_done", done, 1'b0);
        end
        @(negedge clk);
        check("basic_marker_fetch_busy", busy, 1'b1);
        check("basic_marker_fetch_index", index, 2'd2);
        check("basic_marker_fetch_done", done, 1'b0);
        @(negedge clk);
        check("basic_done", done, 1'b1);
        check("basic_done_busy", busy, 1'b0);
        @(negedge clk);
        check("basic_done_pulse_end", done, 1'b0);
        $display("basic playback complete");

        // Full table of so x1, no end marker
        for (int i = 0; i < 4; i++) write_entry(i, 5, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("full_fetch_index", index, 32'(i));
            check("full_fetch_select", select, 5'd0);
            repeat (4) begin
                @(negedge clk);
                check("full_so", select, 5'b10000);
                check("full_so_index", index, 32'(i));
            end
            repeat (2) begin
                @(negedge clk);
                check("full_gap", select, 5'd0);
                check("full_gap_done", done, 1'b0);
            end
            @(negedge clk);
        end
        check("full_done", done, 1'b1);
        check("full_done_busy", busy, 1'b0);
        $display("full table complete");

        // Stop during the third cycle of a note
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("stop_pre_select", select, 5'b10000);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_select", select, 5'd0);
        check("stop_busy", busy, 1'b0);
        check("stop_done", done, 1'b0);
        check("stop_index", index, 2'd0);
        @(negedge clk);
        check("stop_no_done", done, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("replay_busy", busy, 1'b1);
        check("replay_index", index, 2'd0);
        @(negedge clk);
        check("replay_select", select, 5'b10000);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        $display("stop mid-note complete");

        // Write during playback is dropped
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = {3'd1, 4'd3};
        @(negedge clk);
        wr_en = 1'b0;
        stop  = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("busywr_idle", busy, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busywr_ram_unchanged", select, 5'b10000);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", busy, 1'b0);
        @(negedge clk);
        check("startstop_busy2", busy, 1'b0);
        check("startstop_select", select, 5'd0);

        // Write and start in the same cycle: first fetch sees the new entry
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = {3'd2, 4'd1};
        start   = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
        check("wrstart_busy", busy, 1'b1);
        @(negedge clk);
        check("wrstart_select", select, 5'b00010);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("wrstart_stopped", busy, 1'b0);
        $display("write/start interactions complete");

        // Reset during the gap
        write_entry(0, 1, 2);
        write_entry(1, 3, 1);
        write_entry(2, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        check("rstgap_busy_before", busy, 1'b1);
        check("rstgap_select_before", select, 5'd0);
        rst_n = 1'b0;
        #1;
        check("rstgap_busy", busy, 1'b0);
        check("rstgap_select", select, 5'd0);
        check("rstgap_index", index, 2'd0);
        check("rstgap_done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rstgap_replay_busy", busy, 1'b1);
        @(negedge clk);
        check("rstgap_replay_select", select, 5'b00001);
        check("rstgap_replay_index", index, 2'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        $display("reset mid-gap complete");

`ifdef MELODY_LOOP_EN
        write_entry(0, 2, 1);
        write_entry(1, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("loop_fetch_index", index, 2'd0);
            check("loop_fetch_done", done, 1'b0);
            repeat (4) begin
                @(negedge clk);
                check("loop_re", select, 5'b00010);
            end
            repeat (2) begin
                @(negedge clk);
                check("loop_gap", select, 5'd0);
            end
            @(negedge clk);
            check("loop_marker_index", index, 2'd1);
            check("loop_marker_busy", busy, 1'b1);
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("loop_stopped", busy, 1'b0);
        $display("loop playback complete");
`endif

        // Empty melody: end marker at entry 0
        write_entry(0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("empty_fetch_busy", busy, 1'b1);
        @(negedge clk);
        check("empty_done", done, 1'b1);
        check("empty_busy", busy, 1'b0);
        check("empty_select", select, 5'd0);
        @(negedge clk);
        check("empty_done_end", done, 1'b0);
        $display("empty melody complete");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a stored melody by driving the 5-bit note-select input of the triangle note generator over time. A small RAM holds note/duration entries, loaded while idle. On `start`, the block steps through the entries, holding each note for a programmed number of time units, with a fixed silent gap between notes. It sits between the user-control logic (buttons/switches) and the note generator.

## Interface
Parameters:
- `DEPTH`, 16: number of melody entries; address width `AW = $clog2(DEPTH)`.
- `UNIT_CYCLES`, 1000000: clock cycles per duration unit; must be ≥1.
- `GAP_CYCLES`, 50000: silent cycles inserted after every entry; 0 means no gap.

Ports:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `wr_en`, in, 1: write a melody entry; honoured only in IDLE.
- `wr_addr`, in, AW: entry address.
- `wr_data`, in, 7: entry; bits [6:4] are the note code, bits [3:0] are the duration in units.
- `start`, in, 1: level-sampled; accepted only in IDLE.
- `stop`, in, 1: abort playback.
- `select`, out, 5: one-hot note to the generator.
  - bit0 = doi, bit1 = re, bit2 = mi, bit3 = fa, bit4 = so.
  - 0 = silent.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse on normal completion.
- `index`, out, AW: address of the entry currently playing.

## Operation
Note codes:
- 0 = rest.
- 1–5 = doi, re, mi, fa, so.
- 6–7 = rest.

Duration 0 is the end marker.

States:
- **IDLE**
  - `start`=1 and `stop`=0 → FETCH, with `index`=0.
  - `stop` wins over `start`.
- **FETCH** (1 cycle): synchronous RAM read of `index`; `select`=0.
  - Fetched duration 0 → IDLE, pulse `done`.
  - Otherwise → NOTE.
- **NOTE**: `select` = one-hot of the note code (0 for a rest), held for exactly dur×UNIT_CYCLES cycles → GAP.
- **GAP**: `select`=0 for GAP_CYCLES cycles.
  - If `index`=DEPTH-1 → IDLE, pulse `done`.
  - Otherwise `index`+1 → FETCH.
  - When GAP_CYCLES=0, GAP is skipped: NOTE goes directly to the end/next decision.

Rules:
- `stop`=1 in any non-IDLE state → IDLE on the next edge: `select`=0, `index`=0, no `done` pulse.
- The RAM write port is active only in IDLE. Writes while busy are dropped silently.
- A write and `start` in the same IDLE cycle are both performed; the first FETCH sees the new data.
- Duration counter width: `$clog2(15×UNIT_CYCLES+1)`. The counter loads in FETCH and counts down to 1; no wrap.
- Reset forces:
  - state=IDLE
  - `select`=0, `busy`=0, `done`=0, `index`=0
  - counters=0
- Reset does not clear RAM contents. Reset mid-playback silences `select` asynchronously.

## Timing
- `start` sampled at edge N: FETCH during N+1; `select` valid from edge N+2.
- Silence between consecutive notes is GAP_CYCLES+1 cycles (the gap plus the FETCH cycle).
- `done` is high for exactly the one cycle after entering IDLE from FETCH or GAP.
- `busy` drops in the same cycle `done` rises.
- `stop` → `select`=0 one cycle later.

## Configuration
- `MELODY_LOOP_EN` defined:
  - At the end condition (end marker or `index`=DEPTH-1), the block wraps to `index`=0 and enters FETCH instead of finishing; `done` is not pulsed.
  - Playback ends only via `stop` or reset.
  - Exception: an end marker at address 0 still finishes with `done`, so an empty melody cannot spin.
- `MELODY_LOOP_EN` undefined: single-pass behaviour as described above.

## Structure
- Package `melody_pkg` contains:
  - state enum (IDLE, FETCH, NOTE, GAP)
  - note-code constants
  - entry field positions and widths
  - function `note_to_select` (code → one-hot, with rest and 6–7 mapped to 0)
- Sub-module `melody_ram`: DEPTH×7 simple dual-port RAM, with one write port and one synchronous read port, no reset.
- The top level contains only the FSM, the counters and the output registers.

## Test plan
Bench configuration: DEPTH=4, UNIT_CYCLES=4, GAP_CYCLES=2.

- **Basic playback**
  - Stimulus: load {doi,2},{mi,1},{0,0}, then `start`.
  - Required: `select`=00001 for 8 cycles, then 0 for 3 cycles, then 00100 for 4 cycles, then 0 for 2 cycles, then `done` pulses.
- **Full table, no marker**
  - Stimulus: load 4 entries of {so,1}.
  - Required: 4 so-notes, then `done` after `index`=3's gap; `index` sequence is 0,1,2,3.
- **Stop mid-note**
  - Stimulus: assert `stop` during the 3rd cycle of a note.
  - Required: `select`=0 and `busy`=0 next cycle; no `done`; a new `start` replays from `index` 0.
- **Write/start interactions**
  - Stimulus: write during playback.
  - Required: RAM unchanged.
  - Stimulus: `start` and `stop` asserted together in IDLE.
  - Required: remains IDLE.
- **Reset mid-gap**
  - Stimulus: deassert `rst_n` during the gap.
  - Required: all outputs 0 immediately.
  - Stimulus: `start` after reset release.
  - Required: previously loaded melody plays.
- **Loop (MELODY_LOOP_EN)**
  - Stimulus: load {re,1},{0,0}.
  - Required: re/silence repeats indefinitely with no `done`.
  - Stimulus: load {0,0} at address 0.
  - Required: `done` after FETCH.
